// File: rtl/aes_key_expand_128.sv
// aes_key_expand_128 -- iterative AES-128 key schedule.
//
// Takes a 128-bit cipher key and produces the 11 round keys (index 0..10).
// One round key is presented at a time on a valid/ready interface. Each
// accepted transfer advances to the next round key in a single cycle.
//
// Ports:
//   clk       in   1    clock
//   rst_n     in   1    asynchronous active-low reset
//   start     in   1    load request, sampled only when idle
//   key_in    in   128  cipher key, key_in[127:120] = key byte 0
//   rk_valid  out  1    rk_out/rk_idx hold a valid round key
//   rk_ready  in   1    consumer accepts the current round key
//   rk_out    out  128  round key {w[4i], w[4i+1], w[4i+2], w[4i+3]}
//   rk_idx    out  4    round index of rk_out, 0..10
//   busy      out  1    expansion in progress
//   done      out  1    one-cycle pulse after round key 10 is accepted

// Combinational AES S-box, table lookup.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_byte = SBOX[in_byte];

endmodule

module aes_key_expand_128 (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         busy,
  output logic         done
);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t state, state_nxt;

  logic [127:0] rk_out_nxt;
  logic [3:0]   rk_idx_nxt;
  logic         rk_valid_nxt;
  logic         done_nxt;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w3, sub_w3, t_word;
  logic [31:0] n0, n1, n2, n3;
  logic [3:0]  idx_inc;

  // Round constant table; unused indices return zero.
  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  assign {w0, w1, w2, w3} = rk_out;
  assign rot_w3  = {w3[23:0], w3[31:24]};
  assign idx_inc = rk_idx + 4'd1;

  aes_sbox u_sbox0 (.in_byte(rot_w3[31:24]), .out_byte(sub_w3[31:24]));
  aes_sbox u_sbox1 (.in_byte(rot_w3[23:16]), .out_byte(sub_w3[23:16]));
  aes_sbox u_sbox2 (.in_byte(rot_w3[15:8]),  .out_byte(sub_w3[15:8]));
  aes_sbox u_sbox3 (.in_byte(rot_w3[7:0]),   .out_byte(sub_w3[7:0]));

  assign t_word = sub_w3 ^ {rcon(idx_inc), 24'h000000};
  assign n0 = w0 ^ t_word;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign busy = (state == EMIT);

  always_comb begin
    state_nxt    = state;
    rk_out_nxt   = rk_out;
    rk_idx_nxt   = rk_idx;
    rk_valid_nxt = rk_valid;
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt    = EMIT;
          rk_out_nxt   = key_in;
          rk_idx_nxt   = '0;
          rk_valid_nxt = 1'b1;
        end
      end
      EMIT: begin
        if (rk_valid && rk_ready) begin
          if (rk_idx == 4'd10) begin
            // Final transfer: rk_out keeps round key 10.
            state_nxt    = IDLE;
            rk_idx_nxt   = '0;
            rk_valid_nxt = 1'b0;
            done_nxt     = 1'b1;
          end else begin
            rk_out_nxt = {n0, n1, n2, n3};
            rk_idx_nxt = idx_inc;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rk_out   <= '0;
      rk_idx   <= '0;
      rk_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      rk_out   <= rk_out_nxt;
      rk_idx   <= rk_idx_nxt;
      rk_valid <= rk_valid_nxt;
      done     <= done_nxt;
    end
  end

endmodule
